// File: rtl/core_reg_file.sv
// rtl/core_reg_file.sv - banked register file with init sweep, write-through reads and issue scoreboard
module core_reg_file #(
    parameter int              WIDTH      = 32,
    parameter int              ENTRIES    = 30,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rd_index_a,
    input  logic [4:0]       rd_index_b,
    output logic [WIDTH-1:0] rd_value_a,
    output logic [WIDTH-1:0] rd_value_b,
    output logic             pending_a,
    output logic             pending_b,
    input  logic             wr_enable,
    input  logic [4:0]       wr_index,
    input  logic [WIDTH-1:0] wr_value,
    input  logic             mark_enable,
    input  logic [4:0]       mark_index,
    output logic             pending_any,
    output logic             busy
);

    localparam logic [5:0] NUM_ENTRIES = 6'(ENTRIES);
    localparam logic [4:0] LAST_ENTRY  = 5'(ENTRIES - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [4:0]           sweep_ctr;
    logic [WIDTH-1:0]     entry [ENTRIES];
    logic [ENTRIES-1:0]   scoreboard;
    logic [ENTRIES-1:0]   scoreboard_next;
    logic [WIDTH-1:0]     rd_next_a;
    logic [WIDTH-1:0]     rd_next_b;
    logic                 wr_hit;
    logic                 mark_hit;

    function automatic logic in_range(input logic [4:0] idx);
        return {1'b0, idx} < NUM_ENTRIES;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        case (state)
            INIT: begin
                busy = 1'b1;
                if (sweep_ctr == LAST_ENTRY) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                next_state = RUN;
            end
            default: next_state = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_ctr <= '0;
        end else if (state == INIT) begin
            sweep_ctr <= sweep_ctr + 5'd1;
        end
    end

    // Out-of-range indices never touch storage or scoreboard
    assign wr_hit   = (state == RUN) && wr_enable && in_range(wr_index);
    assign mark_hit = (state == RUN) && mark_enable && in_range(mark_index);

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                entry[sweep_ctr] <= INIT_VALUE;
            end else if (wr_hit) begin
                entry[wr_index] <= wr_value;
            end
        end
    end

    // Clear before set so a same-index mark overrides the writeback
    always_comb begin
        scoreboard_next = scoreboard;
        if (wr_hit) begin
            scoreboard_next[wr_index] = 1'b0;
        end
        if (mark_hit) begin
            scoreboard_next[mark_index] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state == INIT) begin
            scoreboard <= '0;
        end else begin
            scoreboard <= scoreboard_next;
        end
    end

    always_comb begin
        rd_next_a = '0;
        if (in_range(rd_index_a)) begin
            if (wr_enable && wr_index == rd_index_a) begin
                rd_next_a = wr_value;
            end else begin
                rd_next_a = entry[rd_index_a];
            end
        end
    end

    always_comb begin
        rd_next_b = '0;
        if (in_range(rd_index_b)) begin
            if (wr_enable && wr_index == rd_index_b) begin
                rd_next_b = wr_value;
            end else begin
                rd_next_b = entry[rd_index_b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state == INIT) begin
            rd_value_a <= '0;
            rd_value_b <= '0;
        end else begin
            rd_value_a <= rd_next_a;
            rd_value_b <= rd_next_b;
        end
    end

    // A writeback landing this cycle already resolves the dependency
    assign pending_a = (state == RUN) && in_range(rd_index_a) && scoreboard[rd_index_a]
                       && !(wr_enable && wr_index == rd_index_a);
    assign pending_b = (state == RUN) && in_range(rd_index_b) && scoreboard[rd_index_b]
                       && !(wr_enable && wr_index == rd_index_b);

    assign pending_any = |scoreboard;

endmodule

// File: tb/tb_core_reg_file.sv
// tb/tb_core_reg_file.sv - directed self-checking bench for core_reg_file
module tb_core_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  rd_index_a;
    logic [4:0]  rd_index_b;
    logic [31:0] rd_value_a;
    logic [31:0] rd_value_b;
    logic        pending_a;
    logic        pending_b;
    logic        wr_enable;
    logic [4:0]  wr_index;
    logic [31:0] wr_value;
    logic        mark_enable;
    logic [4:0]  mark_index;
    logic        pending_any;
    logic        busy;

    int checks;
    int passes;

    core_reg_file dut (
        .clk         (clk),
        .rst         (rst),
        .rd_index_a  (rd_index_a),
        .rd_index_b  (rd_index_b),
        .rd_value_a  (rd_value_a),
        .rd_value_b  (rd_value_b),
        .pending_a   (pending_a),
        .pending_b   (pending_b),
        .wr_enable   (wr_enable),
        .wr_index    (wr_index),
        .wr_value    (wr_value),
        .mark_enable (mark_enable),
        .mark_index  (mark_index),
        .pending_any (pending_any),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(input string name);
        int cnt;
        cnt = 0;
        while (busy && cnt < 100) begin
            checks++;
            if (rd_value_a !== 32'h0 || rd_value_b !== 32'h0 || pending_any !== 1'b0)
                $display("FAIL %s_init_outputs: rd_a=%h rd_b=%h any=%b expected 0/0/0",
                         name, rd_value_a, rd_value_b, pending_any);
            else passes++;
            tick();
            cnt++;
        end
        checks++;
        if (cnt !== 30) $display("FAIL %s_busy_cycles: got %0d expected 30", name, cnt);
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || pending_a !== 1'b0 || pending_b !== 1'b0 || pending_any !== 1'b0)
            $display("FAIL reset_flags: busy=%b pa=%b pb=%b any=%b expected 1/0/0/0",
                     busy, pending_a, pending_b, pending_any);
        else passes++;
        checks++;
        if (rd_value_a !== 32'h0 || rd_value_b !== 32'h0)
            $display("FAIL reset_rd: a=%h b=%h expected 0", rd_value_a, rd_value_b);
        else passes++;
        count_busy("reset");
    endtask

    task automatic test_idle_reads();
        for (int i = 0; i < 30; i++) begin
            rd_index_a = 5'(i);
            rd_index_b = 5'(29 - i);
            tick();
            checks++;
            if (rd_value_a !== 32'h0 || rd_value_b !== 32'h0)
                $display("FAIL idle_read_%0d: a=%h b=%h expected 0", i, rd_value_a, rd_value_b);
            else passes++;
        end
    endtask

    task automatic test_banked_write();
        wr_enable = 1'b1;
        wr_index  = 5'd28;
        wr_value  = 32'hDEADBEEF;
        rd_index_a = 5'd0;
        rd_index_b = 5'd0;
        tick();
        wr_enable  = 1'b0;
        rd_index_a = 5'd28;
        rd_index_b = 5'd13;
        tick();
        checks++;
        if (rd_value_a !== 32'hDEADBEEF)
            $display("FAIL banked_svc_r13: got %h expected deadbeef", rd_value_a);
        else passes++;
        checks++;
        if (rd_value_b !== 32'h0)
            $display("FAIL banked_usr_r13: got %h expected 0", rd_value_b);
        else passes++;
    endtask

    task automatic test_forward();
        wr_enable  = 1'b1;
        wr_index   = 5'd5;
        wr_value   = 32'h12345678;
        rd_index_a = 5'd5;
        rd_index_b = 5'd5;
        #1;
        checks++;
        if (pending_b !== 1'b0)
            $display("FAIL forward_pending_b: got %b expected 0", pending_b);
        else passes++;
        tick();
        wr_enable = 1'b0;
        checks++;
        if (rd_value_b !== 32'h12345678)
            $display("FAIL forward_rd_b: got %h expected 12345678", rd_value_b);
        else passes++;
        checks++;
        if (rd_value_a !== 32'h12345678)
            $display("FAIL forward_rd_a_same_index: got %h expected 12345678", rd_value_a);
        else passes++;
    endtask

    task automatic test_scoreboard();
        mark_enable = 1'b1;
        mark_index  = 5'd20;
        tick();
        mark_enable = 1'b0;
        rd_index_a  = 5'd20;
        #1;
        checks++;
        if (pending_a !== 1'b1 || pending_any !== 1'b1)
            $display("FAIL sb_marked: pa=%b any=%b expected 1/1", pending_a, pending_any);
        else passes++;
        wr_enable = 1'b1;
        wr_index  = 5'd20;
        wr_value  = 32'h00000020;
        #1;
        checks++;
        if (pending_a !== 1'b0 || pending_any !== 1'b1)
            $display("FAIL sb_write_same_cycle: pa=%b any=%b expected 0/1", pending_a, pending_any);
        else passes++;
        tick();
        wr_enable = 1'b0;
        checks++;
        if (pending_a !== 1'b0 || pending_any !== 1'b0)
            $display("FAIL sb_cleared: pa=%b any=%b expected 0/0", pending_a, pending_any);
        else passes++;
    endtask

    task automatic test_mark_write_collide();
        mark_enable = 1'b1;
        mark_index  = 5'd3;
        wr_enable   = 1'b1;
        wr_index    = 5'd3;
        wr_value    = 32'hA5A50003;
        rd_index_a  = 5'd0;
        tick();
        mark_enable = 1'b0;
        wr_enable   = 1'b0;
        rd_index_a  = 5'd3;
        #1;
        checks++;
        if (pending_a !== 1'b1)
            $display("FAIL collide_pending: got %b expected 1", pending_a);
        else passes++;
        tick();
        checks++;
        if (rd_value_a !== 32'hA5A50003 || pending_a !== 1'b1)
            $display("FAIL collide_read: rd=%h pa=%b expected a5a50003/1", rd_value_a, pending_a);
        else passes++;
        // mark 8, then mark 7 while writing 8 in the same cycle
        mark_enable = 1'b1;
        mark_index  = 5'd8;
        tick();
        mark_index = 5'd7;
        wr_enable  = 1'b1;
        wr_index   = 5'd8;
        wr_value   = 32'h00000808;
        tick();
        mark_enable = 1'b0;
        wr_enable   = 1'b0;
        rd_index_a  = 5'd7;
        rd_index_b  = 5'd8;
        #1;
        checks++;
        if (pending_a !== 1'b1 || pending_b !== 1'b0)
            $display("FAIL split_mark_write: pa=%b pb=%b expected 1/0", pending_a, pending_b);
        else passes++;
        tick();
        checks++;
        if (rd_value_b !== 32'h00000808)
            $display("FAIL split_write_data: got %h expected 00000808", rd_value_b);
        else passes++;
        wr_enable = 1'b1;
        wr_index  = 5'd7;
        wr_value  = 32'h0;
        tick();
        wr_index = 5'd3;
        tick();
        wr_enable = 1'b0;
        checks++;
        if (pending_any !== 1'b0)
            $display("FAIL collide_cleanup: any=%b expected 0", pending_any);
        else passes++;
    endtask

    task automatic test_invalid_index();
        wr_enable   = 1'b1;
        wr_index    = 5'd31;
        wr_value    = 32'hFFFFFFFF;
        mark_enable = 1'b1;
        mark_index  = 5'd30;
        rd_index_a  = 5'd31;
        rd_index_b  = 5'd30;
        #1;
        checks++;
        if (pending_a !== 1'b0 || pending_b !== 1'b0)
            $display("FAIL invalid_pending: pa=%b pb=%b expected 0/0", pending_a, pending_b);
        else passes++;
        tick();
        wr_enable   = 1'b0;
        mark_enable = 1'b0;
        checks++;
        if (rd_value_a !== 32'h0 || rd_value_b !== 32'h0 || pending_any !== 1'b0)
            $display("FAIL invalid_read: a=%h b=%h any=%b expected 0/0/0",
                     rd_value_a, rd_value_b, pending_any);
        else passes++;
    endtask

    task automatic test_midsweep_reset();
        mark_enable = 1'b1;
        mark_index  = 5'd10;
        tick();
        mark_index = 5'd11;
        tick();
        mark_enable = 1'b0;
        checks++;
        if (pending_any !== 1'b1)
            $display("FAIL midsweep_premark: any=%b expected 1", pending_any);
        else passes++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr_enable   = 1'b1;
        wr_index    = 5'd28;
        wr_value    = 32'h55555555;
        mark_enable = 1'b1;
        mark_index  = 5'd2;
        #1;
        checks++;
        if (busy !== 1'b1 || pending_any !== 1'b0)
            $display("FAIL midsweep_restart: busy=%b any=%b expected 1/0", busy, pending_any);
        else passes++;
        count_busy("midsweep");
        wr_enable   = 1'b0;
        mark_enable = 1'b0;
        rd_index_a  = 5'd28;
        rd_index_b  = 5'd31;
        #1;
        checks++;
        if (pending_any !== 1'b0)
            $display("FAIL midsweep_marks_dropped: any=%b expected 0", pending_any);
        else passes++;
        tick();
        checks++;
        if (rd_value_a !== 32'h0 || rd_value_b !== 32'h0)
            $display("FAIL midsweep_wiped: a=%h b=%h expected 0/0", rd_value_a, rd_value_b);
        else passes++;
        rd_index_a = 5'd5;
        rd_index_b = 5'd8;
        tick();
        checks++;
        if (rd_value_a !== 32'h0 || rd_value_b !== 32'h0)
            $display("FAIL midsweep_old_data: a=%h b=%h expected 0/0", rd_value_a, rd_value_b);
        else passes++;
    endtask

    initial begin
        checks      = 0;
        passes      = 0;
        rst         = 1'b1;
        rd_index_a  = '0;
        rd_index_b  = '0;
        wr_enable   = 1'b0;
        wr_index    = '0;
        wr_value    = '0;
        mark_enable = 1'b0;
        mark_index  = '0;
        test_reset();
        test_idle_reads();
        test_banked_write();
        test_forward();
        test_scoreboard();
        test_mark_write_collide();
        test_invalid_index();
        test_midsweep_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
